// File: rtl/alu_slice_seq.sv
// Multi-cycle ALU: 16-function arithmetic/logic operation over a WIDTH-bit word,
// evaluated SLICE bits per clock from the least-significant slice upward.
module alu_slice_seq #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [0:3]       S,
    input  logic             M,
    input  logic             CIN,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] F,
    output logic             COUT,
    output logic             ZERO,
    output logic             OVF
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = $clog2(NSLICE + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    k_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, f_q;
    logic [3:0]       s_q;
    logic             m_q, carry_q;
    logic             busy_q, done_q, cout_q, zero_q, ovf_q;

    logic [SLICE-1:0] u, v, sum;
    logic [SLICE:0]   ext;
    logic [WIDTH-1:0] sum_ext, acc_d;
    logic             carry_d, c_top;

    // Operands shift right each RUN cycle, so the active slice is always the low SLICE bits;
    // the result fills from the top and is complete after NSLICE shifts.
    always_comb begin
        u       = a_q[SLICE-1:0] | ({SLICE{s_q[2]}} & b_q[SLICE-1:0])
                                 | ({SLICE{s_q[3]}} & ~b_q[SLICE-1:0]);
        v       = a_q[SLICE-1:0] & (({SLICE{s_q[0]}} & ~b_q[SLICE-1:0])
                                 |  ({SLICE{s_q[1]}} &  b_q[SLICE-1:0]));
        ext     = {1'b0, u} + {1'b0, v} + {{SLICE{1'b0}}, carry_q};
        carry_d = ext[SLICE];
        c_top   = ext[SLICE-1] ^ u[SLICE-1] ^ v[SLICE-1];
        sum     = m_q ? ~(u ^ v) : ext[SLICE-1:0];
        sum_ext = '0;
        sum_ext[SLICE-1:0] = sum;
        acc_d   = (acc_q >> SLICE) | (sum_ext << (WIDTH - SLICE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            f_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        a_q     <= A;
                        b_q     <= B;
                        s_q     <= S;
                        m_q     <= M;
                        carry_q <= CIN;
                        acc_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    k_q     <= k_q + CW'(1);
                    if (k_q == CW'(NSLICE - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        f_q     <= acc_d;
                        zero_q  <= (acc_d == '0);
                        cout_q  <= m_q ? 1'b0 : carry_d;
                        ovf_q   <= m_q ? 1'b0 : (carry_d ^ c_top);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign F    = f_q;
    assign COUT = cout_q;
    assign ZERO = zero_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Bench for alu_slice_seq: directed and random operations against a whole-word arithmetic model.
module tb_alu_slice_seq;

    localparam int unsigned WIDTH  = 36;
    localparam int unsigned SLICE  = 4;
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned LAT    = NSLICE + 1;

    logic             clk = 1'b0;
    logic             reset, start, M, CIN;
    logic [0:3]       S;
    logic [0:WIDTH-1] A, B;
    logic             busy, done, COUT, ZERO, OVF;
    logic [0:WIDTH-1] F;

    int checks = 0;
    int errors = 0;

    logic [35:0] last_f;
    logic [37:0] bexp;
    logic [35:0] ba, bb;
    logic [3:0]  bs;
    logic        bm, bc;
    int          e, seen;

    always #5 clk = ~clk;

    alu_slice_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .reset(reset), .start(start), .S(S), .M(M), .CIN(CIN),
        .A(A), .B(B), .busy(busy), .done(done), .F(F),
        .COUT(COUT), .ZERO(ZERO), .OVF(OVF)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {cout, ovf, f[35:0]}
    function automatic logic [37:0] model(input logic [35:0] a, input logic [35:0] b,
                                          input logic [3:0] s, input logic m, input logic cin);
        logic [35:0] u, w, f;
        logic [36:0] full;
        logic [35:0] low;
        logic        co, ov;
        u = a | (s[2] ? b : '0) | (s[3] ? ~b : '0);
        w = a & ((s[0] ? ~b : '0) | (s[1] ? b : '0));
        if (m) begin
            f  = ~(u ^ w);
            co = 1'b0;
            ov = 1'b0;
        end else begin
            full = {1'b0, u} + {1'b0, w} + 37'(cin);
            low  = {1'b0, u[34:0]} + {1'b0, w[34:0]} + 36'(cin);
            f    = full[35:0];
            co   = full[36];
            ov   = low[35] ^ co;
        end
        return {co, ov, f};
    endfunction

    task automatic scramble();
        A   = WIDTH'({$urandom, $urandom});
        B   = WIDTH'({$urandom, $urandom});
        S   = 4'($urandom);
        M   = 1'($urandom);
        CIN = 1'($urandom);
    endtask

    task automatic run_op(input logic [35:0] a, input logic [35:0] b, input logic [3:0] s,
                          input logic m, input logic cin);
        logic [37:0] exp;
        int edges, bn;
        exp = model(a, b, s, m, cin);
        @(negedge clk);
        A = a; B = b; S = s; M = m; CIN = cin; start = 1'b1;
        edges = 0;
        bn = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) bn++;
            start = 1'b0;
            scramble();
        end while (!done && edges < 40);
        check("latency", 64'(edges), 64'(LAT));
        check("busy_cycles", 64'(bn), 64'(NSLICE));
        check("busy_at_done", 64'(busy), 64'(0));
        check("F", 64'(F), 64'(exp[35:0]));
        check("COUT", 64'(COUT), 64'(exp[37]));
        check("OVF", 64'(OVF), 64'(exp[36]));
        check("ZERO", 64'(ZERO), 64'(exp[35:0] == 36'd0));
        last_f = F;
        @(posedge clk);
        #1;
        check("done_drop", 64'(done), 64'(0));
        check("F_hold", 64'(F), 64'(exp[35:0]));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        A = '0; B = '0; S = '0; M = 1'b0; CIN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_F", 64'(F), 64'(0));
        check("rst_flags", 64'({COUT, ZERO, OVF}), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors with independently known results
        run_op(36'd1, 36'd1, 4'b0110, 1'b0, 1'b0);
        check("add_const", 64'(last_f), 64'(36'd2));
        run_op(36'o777777777777, 36'd1, 4'b0110, 1'b0, 1'b0);
        check("wrap_const", 64'(last_f), 64'(36'd0));
        run_op(36'o377777777777, 36'd1, 4'b0110, 1'b0, 1'b0);
        check("ovf_const", 64'(last_f), 64'(36'o400000000000));
        run_op(36'd5, 36'd7, 4'b1001, 1'b0, 1'b1);
        check("sub_const", 64'(last_f), 64'(36'o777777777776));
        run_op(36'o707070707070, 36'o777700000000, 4'b1001, 1'b1, 1'b1);
        check("xor_const", 64'(last_f), 64'(36'o070770707070));
        run_op(36'o707070707070, 36'o777700000000, 4'b1100, 1'b1, 1'b1);
        check("zero_const", 64'(last_f), 64'(36'd0));
        run_op(36'o123456701234, 36'd0, 4'b1111, 1'b0, 1'b0);
        check("dec_const", 64'(last_f), 64'(36'o123456701233));
        run_op(36'o123456701234, 36'o555555555555, 4'b1010, 1'b1, 1'b0);
        check("passb_const", 64'(last_f), 64'(36'o555555555555));

        for (int i = 0; i < 24; i++) begin
            logic [35:0] ra, rb;
            ra = 36'({$urandom, $urandom});
            rb = 36'({$urandom, $urandom});
            if (i % 6 == 0) ra = '1;
            if (i % 6 == 1) rb = '1;
            if (i % 6 == 2) rb = ra;
            run_op(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom));
        end

        // start held high: ops complete back-to-back, start during busy ignored
        @(negedge clk);
        ba = 36'({$urandom, $urandom}); bb = 36'({$urandom, $urandom});
        bs = 4'($urandom); bm = 1'b0; bc = 1'($urandom);
        A = ba; B = bb; S = bs; M = bm; CIN = bc; start = 1'b1;
        bexp = model(ba, bb, bs, bm, bc);
        for (int i = 0; i < 3; i++) begin
            e = 0;
            do begin
                @(posedge clk);
                #1;
                e++;
                if (!done) scramble();
            end while (!done && e < 40);
            check("b2b_period", 64'(e), 64'(LAT));
            check("b2b_F", 64'(F), 64'(bexp[35:0]));
            check("b2b_flags", 64'({COUT, OVF}), 64'(bexp[37:36]));
            if (i < 2) begin
                ba = 36'({$urandom, $urandom}); bb = 36'({$urandom, $urandom});
                bs = 4'($urandom); bm = 1'($urandom); bc = 1'($urandom);
                A = ba; B = bb; S = bs; M = bm; CIN = bc;
                bexp = model(ba, bb, bs, bm, bc);
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("b2b_end_idle", 64'({busy, done}), 64'(0));

        // Reset in the middle of RUN
        run_op(36'd1, 36'd1, 4'b0110, 1'b0, 1'b0);
        @(negedge clk);
        A = 36'o777777777777; B = 36'd1; S = 4'b0110; M = 1'b0; CIN = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_F", 64'(F), 64'(0));
        check("mid_rst_flags", 64'({done, COUT, ZERO, OVF}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        check("no_done_after_rst", 64'(seen), 64'(0));
        run_op(36'o377777777777, 36'd1, 4'b0110, 1'b0, 1'b0);
        check("post_rst_const", 64'(last_f), 64'(36'o400000000000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_slice_seq.md
# alu_slice_seq

Parametrised sequential ALU that runs the ECL-style 16-function, two-mode arithmetic/logic operation set over a WIDTH-bit word. It processes the word SLICE bits per clock, least-significant slice first, and registers the inter-slice carry. It is the multi-cycle, wide-word successor to the single 4-bit combinational slice. Datapath control logic uses it where a full-width carry chain in one cycle is unnecessary: it presents a start/done handshake and registered result flags.

## Interface
- WIDTH, 36: operand/result width; must be a multiple of SLICE.
- SLICE, 4: bits processed per clock; NSLICE = WIDTH/SLICE.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- S  in  [0:3]  function select; S[0] is the MSB (datasheet S3), S[3] is datasheet S0.
- M  in  1  1 = logic mode, 0 = arithmetic mode.
- CIN  in  1  carry into the least-significant bit (arithmetic only).
- A, B  in  [0:WIDTH-1]  operands; bit 0 is the MSB (big-endian numbering).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result valid.
- F  out  [0:WIDTH-1]  result; held until the next completion.
- COUT  out  1  carry out of bit 0.
- ZERO  out  1  F == 0.
- OVF  out  1  two's-complement overflow (carry into bit 0 XOR carry out of bit 0).

## Operation
- Per bit, with datasheet select names S3..S0:
  - U = A | (S2 & B) | (S3 & ~B)
  - V = A & ((S0 & ~B) | (S1 & B))
- M=0: F = U + V + CIN mod 2^WIDTH.
  - Examples: S=0110 gives A+B+CIN; S=1001 gives A-B-1+CIN; S=1111 gives A-1+CIN; S=1100 gives -1+CIN.
- M=1: F = ~(U ^ V) bitwise.
  - Examples: 0000 gives ~A; 0110 gives ~(A^B); 1001 gives A^B; 1010 gives B; 1100 gives 0; 1111 gives A.
  - CIN is ignored; COUT=0 and OVF=0.
- States:
  - IDLE → RUN when start=1.
  - RUN stays for NSLICE cycles.
  - RUN → IDLE on the last slice.
- On accept: latch A, B, S, M, CIN into internal operand registers. Slice counter = 0. Carry register = CIN.
- Each RUN cycle: compute slice k (bits WIDTH-1-k·SLICE down to WIDTH-SLICE-k·SLICE) from the latched operands and the carry register. Store the partial result; update the carry register; increment k.
- Last slice: write the complete result to F. Set COUT, ZERO, and OVF (OVF from the carries into and out of bit 0). Pulse done.
- Input changes during RUN have no effect on the result.
- start while busy=1 is ignored (not queued).

## Timing
- Reset values: busy=0, done=0, F=0, COUT=0, ZERO=0, OVF=0. State is IDLE and the counter is 0.
- Reset asserted mid-RUN aborts the operation. F and the flags return to 0, and no done pulse follows.
- start sampled at edge E0:
  - busy=1 after E0.
  - Slices are computed at edges E1..E(NSLICE).
  - After E(NSLICE): F and flags are updated, done=1, busy=0.
  - done drops after E(NSLICE+1).
- Latency is NSLICE+1 edges from start to done; 10 with the defaults.
- F and flags change only at completion. Between operations they hold the last result.
- A new start may be asserted in the done cycle (busy=0) and is accepted at that edge. Sustained throughput is one operation per NSLICE+1 cycles.
- SLICE=WIDTH is legal: one RUN cycle, done two edges after start.

## Test plan
- Add, WIDTH=36: A=000000000001, B=000000000001, S=0110, M=0, CIN=0 → F=000000000002, COUT=0, ZERO=0, OVF=0. done is high exactly 10 edges after start, and busy is high for 9 cycles.
- Carry wrap: A=777777777777, B=000000000001, S=0110, M=0, CIN=0 → F=0, COUT=1, ZERO=1, OVF=0.
- Signed overflow: A=377777777777, B=1, S=0110 → F=400000000000, COUT=0, OVF=1. A subtract with S=1001, CIN=1, A=5, B=7 → F=777777777776, COUT=0.
- Logic mode: M=1, S=1001, A=707070707070, B=777700000000, CIN=1 → F=070770707070, COUT=0, OVF=0. Repeat with S=1100 → F=0, ZERO=1.
- Handshake: start held high throughout. Operand changes mid-RUN do not affect F. Operations complete back-to-back every 10 cycles, and start during busy is ignored.
- Reset mid-operation: assert reset at RUN slice 4 → all outputs 0 immediately and no done. A fresh start after release produces the correct result.
